impulse_capture: RTL and testbench
==================================

# impulse_capture

Parametrised multi-channel impulse-response capture engine for the room-correction path. It requests an impulse from the impulse generator, skips a programmable pre-delay, and records `length_in` samples per channel into internal accumulator RAM. It optionally repeats this for 2^k shots and accumulates them, so readback returns the noise-reduced average response. It sits between the audio input sampler and the FIR coefficient loader, which drains results through the read port.

## Interface
- `WIDTH`, 16, signed sample width per channel
- `CHANNELS`, 2, number of simultaneously captured channels
- `MAX_LEN`, 4096, maximum capture length in samples per channel
- `MAX_SHOTS_LOG2`, 3, maximum log2 of shot count; accumulator width is WIDTH+MAX_SHOTS_LOG2
- `audio_clk` in 1: system clock; all logic on rising edge
- `rst_in` in 1: synchronous, active-high reset
- `audio_trigger` in 1: one-cycle sample strobe; at most one every 4 cycles
- `audio_in` in CHANNELS*WIDTH: signed samples; channel c at bits [c*WIDTH +: WIDTH]
- `start_in` in 1: one-cycle capture request
- `abort_in` in 1: one-cycle abort
- `length_in` in $clog2(MAX_LEN+1): samples per channel; sampled on accepted start
- `delay_in` in 8: audio_trigger strobes to skip after impulse; sampled on accepted start
- `shots_log2_in` in $clog2(MAX_SHOTS_LOG2+1): log2 shot count; sampled on accepted start
- `fire_out` out 1: one-cycle pulse to impulse generator
- `impulse_done_in` in 1: one-cycle pulse from generator when impulse finished
- `busy_out` out 1: high in any state other than IDLE/DONE
- `done_out` out 1: level, high in DONE
- `err_out` out 1: one-cycle pulse on rejected start
- `shot_out` out MAX_SHOTS_LOG2+1: index of current shot (0-based)
- `rd_ch_in` in $clog2(CHANNELS) (min 1): readback channel
- `rd_addr_in` in $clog2(MAX_LEN): readback sample index
- `rd_data_out` out WIDTH: averaged sample, 2-cycle latency

## Operation
- States: IDLE, FIRE, WAIT_IMP, DELAY, CAPTURE, DONE.
- IDLE/DONE + start_in:
  - Rejected if length_in==0, length_in>MAX_LEN, or shots_log2_in>MAX_SHOTS_LOG2: err_out pulses, state unchanged.
  - Otherwise latch the config, set shot=0, go to FIRE; done_out clears.
- start_in in any other state: ignored, no err_out.
- FIRE: assert fire_out for exactly one cycle, go to WAIT_IMP.
- WAIT_IMP: on impulse_done_in, go to DELAY with delay counter=0. Any audio_trigger in the same cycle is not counted.
- DELAY: each audio_trigger increments the counter. When counter==delay_in, go to CAPTURE. delay_in==0 means immediate transition, so the first audio_trigger after impulse_done_in is sample 0.
- CAPTURE: each audio_trigger captures sample index i for all channels:
  - shot 0: acc[c][i] = sign-extended sample (overwrite; no stale data survives).
  - shot>0: acc[c][i] += sign-extended sample (read-modify-write).
  - After index length_in-1, if shot < 2^shots_log2-1: shot++, go to FIRE. Otherwise go to DONE.
- Accumulator: signed WIDTH+MAX_SHOTS_LOG2 bits; cannot overflow for legal shot counts.
- Readback: rd_data_out = acc[rd_ch_in][rd_addr_in] >>> shots_log2 (arithmetic shift, floor), truncated to WIDTH.
  - Valid in IDLE-after-DONE and DONE; contents undefined while busy.
  - Addresses ≥ latched length return stale data.
- abort_in (any state, priority over start_in): go to IDLE, clear busy_out/done_out. RAM contents undefined.
- Reset: state IDLE; fire_out=0, busy_out=0, done_out=0, err_out=0, shot_out=0, rd_data_out=0. RAM not cleared.

## Timing
- start_in at cycle t → busy_out=1 and state FIRE at t+1; fire_out=1 during t+1 only.
- Capture RMW pipeline:
  - t: trigger, sample registered.
  - t+1: RAM read.
  - t+2: add.
  - t+3: write committed.
  - The next trigger is ≥4 cycles later, so there is no hazard.
- Last sample's trigger at t → done_out=1, busy_out=0 from t+4.
- Between shots, fire_out pulses at t+4 after the last sample's trigger.
- Read: rd_addr_in/rd_ch_in at t → rd_data_out valid at t+2; fully pipelined, one read per cycle.

## Test plan
- Single shot, CHANNELS=2, length 8, delay 0, ch0 samples 1..8, ch1 −1..−8 → fire_out one pulse; done_out 4 cycles after 8th trigger; readback ch0 idx3=4, ch1 idx7=−8.
- delay_in=3, triggers carry ramp 0,1,2,… after impulse_done_in (including one trigger coincident with it) → stored idx0 = value of 4th post-impulse trigger (3).
- shots_log2=2, per-shot ch0 values 10,11,12,14 at idx0 → fire_out pulses 4 times, shot_out 0..3, readback idx0 = floor(47/4)=11; negative case −10,−11,−12,−14 → −12.
- Rejected config: length_in=0, then length_in=MAX_LEN+1, then shots_log2_in=MAX_SHOTS_LOG2+1 → err_out pulse each, busy_out stays 0, no fire_out.
- abort_in mid-CAPTURE after 5 of 16 samples → IDLE next cycle, busy_out=0, done_out=0. A new start completes normally; shot-0 overwrite ensures correct readback.
- rst_in asserted during DELAY → all outputs 0 next cycle; start_in held during busy is ignored with no err_out.

Source files
------------

// File: rtl/impulse_capture.sv
// Multi-channel impulse-response capture: fires an impulse, skips a pre-delay,
// then records and accumulates 2^k shots per channel into on-chip RAM for averaged readback.
module impulse_capture #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned CHANNELS       = 2,
  parameter int unsigned MAX_LEN        = 4096,
  parameter int unsigned MAX_SHOTS_LOG2 = 3,
  localparam int unsigned LW = $clog2(MAX_LEN + 1),
  localparam int unsigned SW = $clog2(MAX_SHOTS_LOG2 + 1),
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned AW = $clog2(MAX_LEN)
) (
  input  logic                      audio_clk,
  input  logic                      rst_in,
  input  logic                      audio_trigger,
  input  logic [CHANNELS*WIDTH-1:0] audio_in,
  input  logic                      start_in,
  input  logic                      abort_in,
  input  logic [LW-1:0]             length_in,
  input  logic [7:0]                delay_in,
  input  logic [SW-1:0]             shots_log2_in,
  output logic                      fire_out,
  input  logic                      impulse_done_in,
  output logic                      busy_out,
  output logic                      done_out,
  output logic                      err_out,
  output logic [MAX_SHOTS_LOG2:0]   shot_out,
  input  logic [CW-1:0]             rd_ch_in,
  input  logic [AW-1:0]             rd_addr_in,
  output logic [WIDTH-1:0]          rd_data_out
);

  localparam int unsigned ACCW = WIDTH + MAX_SHOTS_LOG2;
  localparam int unsigned HW   = MAX_SHOTS_LOG2 + 1;
  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);
  localparam logic [SW-1:0] MAX_SH_L  = SW'(MAX_SHOTS_LOG2);

  typedef enum logic [2:0] {
    S_IDLE, S_FIRE, S_WAIT_IMP, S_DELAY, S_CAPTURE, S_DONE
  } state_t;

  state_t          state_q;
  logic [LW-1:0]   len_q, idx_q;
  logic [7:0]      delay_q, dcnt_q;
  logic [SW-1:0]   shots_q;
  logic [HW-1:0]   shot_q;
  logic            fire_q, busy_q, done_q, err_q;
  logic [WIDTH-1:0] rd_q;

  logic            s1_q, s2_q, s3_q, l1_q, l2_q, l3_q;
  logic            first1_q, first2_q;
  logic [AW-1:0]   a1_q, a2_q, a3_q;
  logic [CHANNELS*WIDTH-1:0] samp1_q, samp2_q;
  logic [ACCW-1:0] rdv_q [CHANNELS];
  logic [ACCW-1:0] sum_q [CHANNELS];
  logic [ACCW-1:0] ext_d [CHANNELS];
  logic [ACCW-1:0] acc_mem [CHANNELS][MAX_LEN];
  logic [ACCW-1:0] rd_raw_q;

  logic            start_ok_d, cap_d, last_d;
  logic [HW-1:0]   shot_max_d;

  assign start_ok_d = (length_in != '0) && (length_in <= MAX_LEN_L) &&
                      (shots_log2_in <= MAX_SH_L);
  assign cap_d      = (state_q == S_CAPTURE) && audio_trigger && (idx_q != len_q);
  assign last_d     = (idx_q == len_q - LW'(1));
  assign shot_max_d = HW'((32'd1 << shots_q) - 32'd1);

  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      fire_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      shot_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      delay_q <= '0;
      dcnt_q  <= '0;
      shots_q <= '0;
    end else begin
      fire_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort_in) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (start_in) begin
              if (start_ok_d) begin
                len_q   <= length_in;
                delay_q <= delay_in;
                shots_q <= shots_log2_in;
                shot_q  <= '0;
                state_q <= S_FIRE;
                fire_q  <= 1'b1;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          S_FIRE: state_q <= S_WAIT_IMP;
          S_WAIT_IMP: begin
            if (impulse_done_in) begin
              dcnt_q  <= '0;
              idx_q   <= '0;
              // zero delay skips DELAY so the very next trigger is sample 0
              state_q <= (delay_q == '0) ? S_CAPTURE : S_DELAY;
            end
          end
          S_DELAY: begin
            if (audio_trigger) begin
              dcnt_q <= dcnt_q + 8'd1;
              if (dcnt_q + 8'd1 == delay_q) state_q <= S_CAPTURE;
            end
          end
          S_CAPTURE: begin
            if (cap_d) idx_q <= idx_q + LW'(1);
            // leave only once the last sample's write is committing
            if (s3_q && l3_q) begin
              if (shot_q < shot_max_d) begin
                shot_q  <= shot_q + HW'(1);
                state_q <= S_FIRE;
                fire_q  <= 1'b1;
              end else begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge audio_clk) begin
    if (rst_in || abort_in) begin
      s1_q <= 1'b0; s2_q <= 1'b0; s3_q <= 1'b0;
      l1_q <= 1'b0; l2_q <= 1'b0; l3_q <= 1'b0;
    end else begin
      s1_q <= cap_d;
      l1_q <= cap_d && last_d;
      s2_q <= s1_q; l2_q <= l1_q;
      s3_q <= s2_q; l3_q <= l2_q;
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++)
      ext_d[c] = {{MAX_SHOTS_LOG2{samp2_q[c*WIDTH + WIDTH - 1]}}, samp2_q[c*WIDTH +: WIDTH]};
  end

  always_ff @(posedge audio_clk) begin
    if (cap_d) begin
      samp1_q  <= audio_in;
      a1_q     <= idx_q[AW-1:0];
      first1_q <= (shot_q == '0);
    end
    samp2_q  <= samp1_q;
    first2_q <= first1_q;
    a2_q     <= a1_q;
    a3_q     <= a2_q;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      rdv_q[c] <= acc_mem[c][a1_q];
      sum_q[c] <= first2_q ? ext_d[c] : rdv_q[c] + ext_d[c];
      if (s3_q) acc_mem[c][a3_q] <= sum_q[c];
    end
    if (32'(rd_ch_in) < CHANNELS) rd_raw_q <= acc_mem[rd_ch_in][rd_addr_in];
    else                          rd_raw_q <= '0;
  end

  always_ff @(posedge audio_clk) begin
    if (rst_in) rd_q <= '0;
    else        rd_q <= WIDTH'($signed(rd_raw_q) >>> shots_q);
  end

  assign fire_out    = fire_q;
  assign busy_out    = busy_q;
  assign done_out    = done_q;
  assign err_out     = err_q;
  assign shot_out    = shot_q;
  assign rd_data_out = rd_q;

endmodule

// File: tb/tb_impulse_capture.sv
// Scoreboard bench for impulse_capture: stimulus pushes expected fire/err/readback
// events into queues, a negedge monitor pops and compares as the DUT presents them.
module tb_impulse_capture;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CH    = 2;
  localparam int unsigned MLEN  = 16;
  localparam int unsigned MSH   = 2;
  localparam int unsigned LW    = $clog2(MLEN + 1);
  localparam int unsigned SW    = $clog2(MSH + 1);
  localparam int unsigned AW    = $clog2(MLEN);

  logic                   clk = 1'b0;
  logic                   rst_in, audio_trigger, start_in, abort_in, impulse_done_in;
  logic [CH*WIDTH-1:0]    audio_in;
  logic [LW-1:0]          length_in;
  logic [7:0]             delay_in;
  logic [SW-1:0]          shots_log2_in;
  logic                   fire_out, busy_out, done_out, err_out;
  logic [MSH:0]           shot_out;
  logic [0:0]             rd_ch_in;
  logic [AW-1:0]          rd_addr_in;
  logic [WIDTH-1:0]       rd_data_out;
  logic                   rd_issue;

  int n_checks = 0;
  int n_fail   = 0;
  int fq[$];
  int rq[$];
  int err_pending = 0;

  impulse_capture #(.WIDTH(WIDTH), .CHANNELS(CH), .MAX_LEN(MLEN), .MAX_SHOTS_LOG2(MSH)) dut (
    .audio_clk(clk), .rst_in(rst_in), .audio_trigger(audio_trigger), .audio_in(audio_in),
    .start_in(start_in), .abort_in(abort_in), .length_in(length_in), .delay_in(delay_in),
    .shots_log2_in(shots_log2_in), .fire_out(fire_out), .impulse_done_in(impulse_done_in),
    .busy_out(busy_out), .done_out(done_out), .err_out(err_out), .shot_out(shot_out),
    .rd_ch_in(rd_ch_in), .rd_addr_in(rd_addr_in), .rd_data_out(rd_data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start(input int len, input int dly, input int sh);
    length_in = LW'(len); delay_in = 8'(dly); shots_log2_in = SW'(sh);
    start_in = 1'b1; tick(); start_in = 1'b0;
  endtask

  task automatic impulse();
    impulse_done_in = 1'b1; tick(); impulse_done_in = 1'b0;
  endtask

  task automatic trig(input int c0, input int c1);
    audio_in = {16'(c1), 16'(c0)};
    audio_trigger = 1'b1; tick(); audio_trigger = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic rd(input int ch, input int addr, input int exp);
    rq.push_back(exp);
    rd_ch_in = 1'(ch); rd_addr_in = AW'(addr); rd_issue = 1'b1;
    tick();
  endtask

  task automatic rd_end();
    rd_issue = 1'b0; tick(); tick(); tick();
  endtask

  // monitor: fire pulses carry the shot index, err pulses must be expected,
  // readback data appears two cycles after the address was presented
  initial begin
    logic [1:0] rp;
    rp = 2'b00;
    forever begin
      @(negedge clk);
      if (fire_out === 1'b1) begin
        if (fq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL fire_unexpected: fire_out=1 expected 0");
        end else chk("fire_shot", int'(shot_out), fq.pop_front());
      end
      if (err_out === 1'b1) begin
        n_checks++;
        if (err_pending == 0) begin
          n_fail++;
          $display("FAIL err_unexpected: err_out=1 expected 0");
        end else err_pending--;
      end
      if (rp[1]) begin
        if (rq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rd_unexpected: no expected value queued");
        end else chk("rd_data", int'($signed(rd_data_out)), rq.pop_front());
      end
      rp = {rp[0], rd_issue};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v3 [4];
    v3 = '{10, 11, 12, 14};
    rst_in = 1'b1; audio_trigger = 1'b0; start_in = 1'b0; abort_in = 1'b0;
    impulse_done_in = 1'b0; audio_in = '0; length_in = '0; delay_in = '0;
    shots_log2_in = '0; rd_ch_in = '0; rd_addr_in = '0; rd_issue = 1'b0;
    tick(); tick();
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_done", int'(done_out), 0);
    chk("rst_fire", int'(fire_out), 0);
    chk("rst_err", int'(err_out), 0);
    chk("rst_shot", int'(shot_out), 0);
    chk("rst_rd", int'(rd_data_out), 0);
    rst_in = 1'b0; tick();

    // single shot, length 8, delay 0
    fq.push_back(0);
    start(8, 0, 0);
    chk("t1_busy", int'(busy_out), 1);
    tick();
    impulse();
    for (int i = 1; i <= 7; i++) trig(i, -i);
    audio_in = {16'(-8), 16'(8)};
    audio_trigger = 1'b1; tick(); audio_trigger = 1'b0;
    tick(); tick();
    chk("t1_done_early", int'(done_out), 0);
    tick();
    chk("t1_done", int'(done_out), 1);
    chk("t1_busy_end", int'(busy_out), 0);
    for (int i = 0; i < 8; i++) begin
      rd(0, i, i + 1);
      rd(1, i, -(i + 1));
    end
    rd_end();

    // delay 3 with a trigger coincident with impulse_done
    fq.push_back(0);
    start(2, 3, 0);
    chk("t2_done_clr", int'(done_out), 0);
    tick();
    audio_in = {16'(-99), 16'(99)};
    impulse_done_in = 1'b1; audio_trigger = 1'b1; tick();
    impulse_done_in = 1'b0; audio_trigger = 1'b0;
    tick(); tick(); tick();
    for (int v = 0; v <= 4; v++) trig(v, -v);
    chk("t2_done", int'(done_out), 1);
    rd(0, 0, 3); rd(0, 1, 4); rd(1, 0, -3); rd(1, 1, -4);
    rd(0, 5, 6);
    rd_end();

    // four shots averaged, positive on ch0 and negative on ch1
    for (int s = 0; s < 4; s++) fq.push_back(s);
    start(1, 0, 2);
    for (int s = 0; s < 4; s++) begin
      tick();
      impulse();
      trig(v3[s], -v3[s]);
      if (s < 3) chk("t3_fire_gap", int'(fire_out), 1);
    end
    chk("t3_done", int'(done_out), 1);
    chk("t3_busy", int'(busy_out), 0);
    rd(0, 0, 11); rd(1, 0, -12);
    rd_end();

    // rejected configurations leave DONE untouched
    err_pending++; start(0, 0, 0);
    chk("t4_len0_busy", int'(busy_out), 0);
    err_pending++; start(MLEN + 1, 0, 0);
    chk("t4_lenmax_busy", int'(busy_out), 0);
    err_pending++; start(4, 0, MSH + 1);
    chk("t4_shots_busy", int'(busy_out), 0);
    tick();
    chk("t4_done_kept", int'(done_out), 1);
    chk("t4_err_seen", err_pending, 0);
    rd(0, 0, 11);
    rd_end();

    // abort mid-capture, then full-length rerun overwrites
    fq.push_back(0);
    start(16, 0, 0);
    tick();
    impulse();
    for (int i = 0; i < 5; i++) trig(1000 + i, -1000 - i);
    abort_in = 1'b1; tick(); abort_in = 1'b0;
    chk("t5_abort_busy", int'(busy_out), 0);
    chk("t5_abort_done", int'(done_out), 0);
    tick();
    fq.push_back(0);
    start(16, 0, 0);
    tick();
    impulse();
    for (int i = 0; i < 16; i++) trig(20 * i - 150, 7 * i + 3);
    chk("t5_done", int'(done_out), 1);
    rd(0, 0, -150); rd(1, 0, 3); rd(0, 4, -70); rd(1, 4, 31);
    rd(0, 15, 150); rd(1, 15, 108);
    rd_end();

    // start while busy ignored, reset during DELAY
    fq.push_back(0);
    start(4, 5, 0);
    tick();
    impulse();
    trig(1, 1);
    start(4, 0, 0);
    chk("t6_busy_held", int'(busy_out), 1);
    tick();
    rst_in = 1'b1; tick();
    chk("t6_rst_busy", int'(busy_out), 0);
    chk("t6_rst_done", int'(done_out), 0);
    chk("t6_rst_fire", int'(fire_out), 0);
    chk("t6_rst_err", int'(err_out), 0);
    chk("t6_rst_shot", int'(shot_out), 0);
    chk("t6_rst_rd", int'(rd_data_out), 0);
    rst_in = 1'b0;
    tick(); tick(); tick();

    chk("fire_queue_left", fq.size(), 0);
    chk("rd_queue_left", rq.size(), 0);
    chk("err_left", err_pending, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
